// File: rtl/mdu_pkg.sv
// mdu_pkg: op codes, FSM states and op classification helpers for the multiply/divide unit
package mdu_pkg;
  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_t;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  function automatic logic is_muldiv(input logic [2:0] op);
    return op == OP_MULT || op == OP_MULTU || op == OP_DIV || op == OP_DIVU;
  endfunction
  function automatic logic is_div(input logic [2:0] op);
    return op == OP_DIV || op == OP_DIVU;
  endfunction
endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational product or quotient/remainder with divide-by-zero flag
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] ph,
  output logic [31:0] pl,
  output logic        div0
);
  logic        sdiv, na, nb;
  logic [31:0] ua, ub, q, r, qs, rs;
  logic [63:0] ea, eb, prod;
  assign sdiv = op == OP_DIV;
  assign na   = sdiv & a[31];
  assign nb   = sdiv & b[31];
  // divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow trouble
  assign ua   = na ? -a : a;
  assign ub   = nb ? -b : b;
  assign div0 = b == 32'd0;
  assign q    = div0 ? 32'd0 : ua / ub;
  assign r    = div0 ? 32'd0 : ua % ub;
  assign qs   = (na ^ nb) ? -q : q;
  assign rs   = na ? -r : r;
  assign ea   = op == OP_MULT ? {{32{a[31]}}, a} : {32'd0, a};
  assign eb   = op == OP_MULT ? {{32{b[31]}}, b} : {32'd0, b};
  assign prod = ea * eb;
  assign ph   = is_div(op) ? rs : prod[63:32];
  assign pl   = is_div(op) ? qs : prod[31:0];
endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit holding the architectural HI/LO registers
module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [31:0] ph, pl, cph, cpl;
  logic        pd0, cdiv0, accept, last;
  mdu_calc u_calc (.op(op), .a(a), .b(b), .ph(cph), .pl(cpl), .div0(cdiv0));
  assign busy      = state == RUN;
  assign stall_req = busy | (start & is_muldiv(op));
  assign accept    = state == IDLE && start && is_muldiv(op);
  assign last      = cnt == 16'd1;
  always_comb begin
    state_nxt = state == IDLE ? (accept ? RUN : IDLE) : (last ? IDLE : RUN);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 16'd0;
      ph    <= 32'd0;
      pl    <= 32'd0;
      pd0   <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      state <= state_nxt;
      if (state == RUN) begin
        cnt <= cnt - 16'd1;
        if (last && !pd0) begin
          hi <= ph;
          lo <= pl;
        end
      end else if (accept) begin
        cnt <= is_div(op) ? 16'(DIV_CYCLES) : 16'(MULT_CYCLES);
        ph  <= cph;
        pl  <= cpl;
        pd0 <= is_div(op) & cdiv0;
      end else if (start && op == OP_MTHI) begin
        hi <= a;
      end else if (start && op == OP_MTLO) begin
        lo <= a;
      end
    end
  end
endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: directed self-checking bench for the HI/LO multiply/divide unit
module tb_mdu_hilo;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, stall_req;
  logic [31:0] hi, lo;
  int vecs = 0;
  int errs = 0;
  mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
  );
  always #5 clk = ~clk;
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'd0;
  endtask
  task automatic test_reset;
    start = 1'b1; op = 3'd1;
    #2;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b want 0", busy); end
    vecs++; if (stall_req !== 1'b1) begin errs++; $display("FAIL reset_stall_mult got %b want 1", stall_req); end
    vecs++; if (hi !== 32'd0 || lo !== 32'd0) begin errs++; $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo); end
    op = 3'd5;
    #1;
    vecs++; if (stall_req !== 1'b0) begin errs++; $display("FAIL reset_stall_mthi got %b want 0", stall_req); end
    start = 1'b0; op = 3'd0;
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_multu;
    issue(3'd2, 32'hFFFF_FFFF, 32'd2);
    for (int i = 0; i < 5; i++) begin
      vecs++; if (busy !== 1'b1 || hi !== 32'd0) begin errs++; $display("FAIL multu_busy cyc %0d got busy=%b hi=%h want 1/0", i, busy, hi); end
      @(posedge clk); #1;
    end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL multu_done got busy=%b want 0", busy); end
    vecs++; if (hi !== 32'h1 || lo !== 32'hFFFF_FFFE) begin errs++; $display("FAIL multu_res got %h/%h want 00000001/fffffffe", hi, lo); end
  endtask
  task automatic test_mult;
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    repeat (5) begin @(posedge clk); #1; end
    vecs++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin errs++; $display("FAIL mult_res got %h/%h want ffffffff/fffffffe", hi, lo); end
  endtask
  task automatic test_div;
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    for (int i = 0; i < 10; i++) begin
      vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL div_busy cyc %0d got %b want 1", i, busy); end
      @(posedge clk); #1;
    end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL div_done got busy=%b want 0", busy); end
    vecs++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin errs++; $display("FAIL div_res got %h/%h want ffffffff/fffffffd", hi, lo); end
    issue(3'd4, 32'd7, 32'd2);
    repeat (10) begin @(posedge clk); #1; end
    vecs++; if (hi !== 32'd1 || lo !== 32'd3) begin errs++; $display("FAIL divu_res got %h/%h want 1/3", hi, lo); end
  endtask
  task automatic test_div0_overflow;
    issue(3'd5, 32'h11, 32'd0);
    issue(3'd6, 32'h22, 32'd0);
    issue(3'd4, 32'd5, 32'd0);
    for (int i = 0; i < 10; i++) begin
      vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL div0_busy cyc %0d got %b want 1", i, busy); end
      @(posedge clk); #1;
    end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL div0_done got busy=%b want 0", busy); end
    vecs++; if (hi !== 32'h11 || lo !== 32'h22) begin errs++; $display("FAIL div0_keep got %h/%h want 11/22", hi, lo); end
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (10) begin @(posedge clk); #1; end
    vecs++; if (hi !== 32'd0 || lo !== 32'h8000_0000) begin errs++; $display("FAIL div_ovf got %h/%h want 0/80000000", hi, lo); end
  endtask
  task automatic test_start_ignored;
    issue(3'd5, 32'hAB, 32'd0);
    vecs++; if (hi !== 32'hAB || busy !== 1'b0) begin errs++; $display("FAIL mthi got hi=%h busy=%b want ab/0", hi, busy); end
    issue(3'd2, 32'd3, 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b1;
      op = (i == 1) ? 3'd2 : 3'd6;
      a = 32'd5; b = 32'd5;
      #1;
      vecs++; if (stall_req !== 1'b1) begin errs++; $display("FAIL run_stall cyc %0d got %b want 1", i, stall_req); end
      @(posedge clk); #1;
    end
    start = 1'b0; op = 3'd0;
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL run_noextend got busy=%b want 0", busy); end
    vecs++; if (hi !== 32'd0 || lo !== 32'd12) begin errs++; $display("FAIL run_ignored got %h/%h want 0/c", hi, lo); end
    @(posedge clk); #1;
    vecs++; if (busy !== 1'b0 || lo !== 32'd12) begin errs++; $display("FAIL run_norestart got busy=%b lo=%h want 0/c", busy, lo); end
  endtask
  task automatic test_back_to_back;
    issue(3'd2, 32'd6, 32'd7);
    repeat (5) begin @(posedge clk); #1; end
    issue(3'd4, 32'd100, 32'd7);
    vecs++; if (busy !== 1'b1 || lo !== 32'd42 || hi !== 32'd0) begin errs++; $display("FAIL b2b_first got busy=%b %h/%h want 1 0/2a", busy, hi, lo); end
    repeat (10) begin @(posedge clk); #1; end
    vecs++; if (busy !== 1'b0 || hi !== 32'd2 || lo !== 32'd14) begin errs++; $display("FAIL b2b_second got busy=%b %h/%h want 0 2/e", busy, hi, lo); end
  endtask
  task automatic test_reset_mid_op;
    issue(3'd5, 32'h55, 32'd0);
    issue(3'd3, 32'd100, 32'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    vecs++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errs++; $display("FAIL rst_abort got busy=%b %h/%h want 0 0/0", busy, hi, lo); end
    @(negedge clk); reset_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    vecs++; if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin errs++; $display("FAIL rst_nocommit got busy=%b %h/%h want 0 0/0", busy, hi, lo); end
  endtask
  initial begin
    test_reset;
    test_multu;
    test_mult;
    test_div;
    test_div0_overflow;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid_op;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
